// File: rtl/cmp_min_seq.sv
// rtl/cmp_min_seq.sv - sequences a shared comparator over a streamed burst to find min (and optionally max)
//
// Optional feature macro: CMP_MINSEQ_MAX_EN (adds a second comparator tracking max_val/max_idx)
//
// Ports:
//   clk, reset           clock; asynchronous active-high reset
//   start                begin a new burst (sampled only in IDLE)
//   din/din_valid/din_last/din_ready  operand stream handshake
//   busy                 high in every state except IDLE
//   done                 one-cycle pulse, results valid
//   min_val/min_idx      minimum of burst and index of its first occurrence
//   count_out            words accepted in the burst
//   overflow             burst reached COUNT words without din_last
//   max_val/max_idx      maximum and its first index (zero when feature disabled)

module comparator #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             lt
);
    assign lt = (a < b);
endmodule

module cmp_min_seq #(
    parameter  int WIDTH = 3,
    parameter  int COUNT = 8,
    localparam int IDXW  = $clog2(COUNT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             din_last,
    output logic             din_ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] min_val,
    output logic [IDXW-1:0]  min_idx,
    output logic [IDXW:0]    count_out,
    output logic             overflow,
    output logic [WIDTH-1:0] max_val,
    output logic [IDXW-1:0]  max_idx
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCEPT  = 2'd1,
        COMPARE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] cand;
    logic [IDXW-1:0]  cand_idx;
    logic [IDXW:0]    count;
    logic             last_r;
    logic             min_lt;

    comparator #(.WIDTH(WIDTH)) u_cmp_min (
        .a  (cand),
        .b  (min_val),
        .lt (min_lt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cand     <= '0;
            cand_idx <= '0;
            count    <= '0;
            last_r   <= 1'b0;
            overflow <= 1'b0;
            min_val  <= '0;
            min_idx  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        count    <= '0;
                        cand_idx <= '0;
                        overflow <= 1'b0;
                        last_r   <= 1'b0;
                    end
                end
                ACCEPT: begin
                    if (din_valid) begin
                        cand     <= din;
                        cand_idx <= count[IDXW-1:0];
                        count    <= count + 1'b1;
                        // An explicit din_last on the final slot wins, so overflow
                        // only flags bursts that ran out of room unannounced.
                        if (din_last) begin
                            last_r <= 1'b1;
                        end else if (count == (IDXW+1)'(COUNT - 1)) begin
                            last_r   <= 1'b1;
                            overflow <= 1'b1;
                        end else begin
                            last_r <= 1'b0;
                        end
                    end
                end
                COMPARE: begin
                    // Strict less-than keeps the earliest index on ties.
                    if (cand_idx == '0 || min_lt) begin
                        min_val <= cand;
                        min_idx <= cand_idx;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        din_ready = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = ACCEPT;
            end
            ACCEPT: begin
                din_ready = 1'b1;
                if (din_valid) state_nxt = COMPARE;
            end
            COMPARE: begin
                state_nxt = last_r ? DONE : ACCEPT;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign count_out = count;

`ifdef CMP_MINSEQ_MAX_EN
    logic             max_lt;
    logic [WIDTH-1:0] max_val_r;
    logic [IDXW-1:0]  max_idx_r;

    comparator #(.WIDTH(WIDTH)) u_cmp_max (
        .a  (max_val_r),
        .b  (cand),
        .lt (max_lt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            max_val_r <= '0;
            max_idx_r <= '0;
        end else if (state == COMPARE && (cand_idx == '0 || max_lt)) begin
            max_val_r <= cand;
            max_idx_r <= cand_idx;
        end
    end

    assign max_val = max_val_r;
    assign max_idx = max_idx_r;
`else
    assign max_val = '0;
    assign max_idx = '0;
`endif

endmodule

// File: tb/tb_cmp_min_seq.sv
// tb/tb_cmp_min_seq.sv - directed self-checking bench for cmp_min_seq
module tb_cmp_min_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [2:0] din;
    logic       din_valid;
    logic       din_last;
    logic       din_ready;
    logic       busy;
    logic       done;
    logic [2:0] min_val;
    logic [2:0] min_idx;
    logic [3:0] count_out;
    logic       overflow;
    logic [2:0] max_val;
    logic [2:0] max_idx;

    int passed = 0;
    int total  = 0;

    cmp_min_seq #(.WIDTH(3), .COUNT(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .din       (din),
        .din_valid (din_valid),
        .din_last  (din_last),
        .din_ready (din_ready),
        .busy      (busy),
        .done      (done),
        .min_val   (min_val),
        .min_idx   (min_idx),
        .count_out (count_out),
        .overflow  (overflow),
        .max_val   (max_val),
        .max_idx   (max_idx)
    );

    always #5 clk = ~clk;

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Presents one word and returns at the negedge after it was accepted.
    task automatic send(input logic [2:0] v, input logic l);
        int n;
        din = v; din_valid = 1'b1; din_last = l;
        n = 0;
        while (!din_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (din_ready !== 1'b1)
            $display("FAIL send_timeout: din_ready=%b required 1", din_ready);
        else
            passed++;
        @(negedge clk);
        din_valid = 1'b0; din_last = 1'b0;
    endtask

    // Called right after the final send: done must rise exactly one cycle later.
    task automatic check_done(input string name, input logic [2:0] emin, input logic [2:0] eidx,
                              input logic [3:0] ecnt, input logic eovf);
        total++;
        if (done !== 1'b0) $display("FAIL %s_early_done: done=%b required 0", name, done);
        else passed++;
        @(negedge clk);
        total++;
        if (done !== 1'b1) $display("FAIL %s_done: done=%b required 1", name, done);
        else passed++;
        total++;
        if ({min_val, min_idx, count_out, overflow} !== {emin, eidx, ecnt, eovf})
            $display("FAIL %s_result: min=%0d idx=%0d cnt=%0d ovf=%b required min=%0d idx=%0d cnt=%0d ovf=%b",
                     name, min_val, min_idx, count_out, overflow, emin, eidx, ecnt, eovf);
        else passed++;
        @(negedge clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || min_val !== emin || count_out !== ecnt)
            $display("FAIL %s_hold: done=%b busy=%b min=%0d cnt=%0d required done=0 busy=0 min=%0d cnt=%0d",
                     name, done, busy, min_val, count_out, emin, ecnt);
        else passed++;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; din = '0; din_valid = 1'b0; din_last = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({din_ready, busy, done, min_val, count_out, overflow} !== 11'b0)
            $display("FAIL reset_state: rdy=%b busy=%b done=%b min=%0d cnt=%0d ovf=%b required all 0",
                     din_ready, busy, done, min_val, count_out, overflow);
        else passed++;
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (din_ready !== 1'b0 || busy !== 1'b0)
            $display("FAIL idle_state: rdy=%b busy=%b required 0 0", din_ready, busy);
        else passed++;
    endtask

    task automatic test_burst();
        pulse_start();
        total++;
        if (busy !== 1'b1 || din_ready !== 1'b1)
            $display("FAIL accept_state: busy=%b rdy=%b required 1 1", busy, din_ready);
        else passed++;
        send(3'd5, 1'b0); send(3'd3, 1'b0); send(3'd7, 1'b0); send(3'd3, 1'b0);
        send(3'd6, 1'b1);
        check_done("burst", 3'd3, 3'd1, 4'd5, 1'b0);
`ifdef CMP_MINSEQ_MAX_EN
        total++;
        if (max_val !== 3'd7 || max_idx !== 3'd2)
            $display("FAIL burst_max: max=%0d idx=%0d required 7 2", max_val, max_idx);
        else passed++;
`else
        total++;
        if (max_val !== 3'd0 || max_idx !== 3'd0)
            $display("FAIL burst_max_tied: max=%0d idx=%0d required 0 0", max_val, max_idx);
        else passed++;
`endif
    endtask

    task automatic test_single();
        pulse_start();
        send(3'd4, 1'b1);
        check_done("single", 3'd4, 3'd0, 4'd1, 1'b0);
    endtask

    task automatic test_overflow();
        pulse_start();
        for (int i = 7; i >= 1; i--) send(3'(i), 1'b0);
        send(3'd0, 1'b0);
        check_done("overflow", 3'd0, 3'd7, 4'd8, 1'b1);
    endtask

    task automatic test_last_on_full();
        pulse_start();
        send(3'd2, 1'b0); send(3'd6, 1'b0); send(3'd1, 1'b0); send(3'd4, 1'b0);
        send(3'd1, 1'b0); send(3'd5, 1'b0); send(3'd3, 1'b0); send(3'd7, 1'b1);
        check_done("last_full", 3'd1, 3'd2, 4'd8, 1'b0);
    endtask

    task automatic test_gaps();
        pulse_start();
        repeat (3) @(negedge clk);
        total++;
        if (din_ready !== 1'b1 || count_out !== 4'd0)
            $display("FAIL gap_wait: rdy=%b cnt=%0d required 1 0", din_ready, count_out);
        else passed++;
        send(3'd2, 1'b0);
        start = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        total++;
        if (count_out !== 4'd1 || busy !== 1'b1)
            $display("FAIL gap_start_ignored: cnt=%0d busy=%b required 1 1", count_out, busy);
        else passed++;
        send(3'd1, 1'b1);
        check_done("gaps", 3'd1, 3'd1, 4'd2, 1'b0);
    endtask

    task automatic test_reset_mid();
        pulse_start();
        send(3'd6, 1'b0); send(3'd5, 1'b0);
        #2 reset = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0 || count_out !== 4'd0 || min_val !== 3'd0)
            $display("FAIL async_reset: busy=%b cnt=%0d min=%0d required 0 0 0", busy, count_out, min_val);
        else passed++;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        pulse_start();
        send(3'd3, 1'b0); send(3'd1, 1'b1);
        check_done("reset_mid", 3'd1, 3'd1, 4'd2, 1'b0);
    endtask

    initial begin
        test_reset();
        test_burst();
        test_single();
        test_overflow();
        test_last_on_full();
        test_gaps();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
